ctc_multi: RTL and testbench
============================

# ctc_multi

Parametrised multi-channel counter/timer controller, the next generation of the two-channel Minisys CTC. It provides CHANNELS independent down-counters that run either as timers (system clock with a programmable prescaler) or as event counters (synchronised external pulses). It adds auto-reload, pulse or toggle output, and a maskable interrupt. The block sits on the CPU I/O bus behind the CTC chip select and is fully synchronous to one clock.

## Interface
- CHANNELS, 2, number of channels; allowed values are 1, 2, 4, 8.
- WIDTH, 16, counter and bus data width; minimum 16.
- AW, $clog2(CHANNELS)+2, address width (derived; do not override).
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- Select  in  1  chip select; bus accesses are ignored when it is 0.
- Read_enable  in  1  read strobe; has priority over Write_enable.
- Write_enable  in  1  write strobe.
- Address  in  AW  address; {channel[AW-3:0], reg[1:0]}.
- Write_data_in  in  WIDTH  write data.
- Read_data_out  out  WIDTH  registered read data.
- Pulse_in  in  CHANNELS  external count pulses, asynchronous.
- CTC_output  out  CHANNELS  per-channel output.
- irq  out  1  OR of the enabled per-channel done flags.

## Operation
- Register map, per channel, selected by reg:
  - 0: mode (read/write).
  - 1: status (read-only; writes are ignored).
  - 2: init (read/write).
  - 3: current counter (read-only).
- Mode bits:
  - [0] 0 = timer, 1 = counter.
  - [1] auto-reload.
  - [2] irq enable.
  - [3] output style: 0 = one-cycle low pulse, 1 = toggle.
  - [15:8] prescale P (timer mode only).
  - All other bits read back as 0.
- Status bits:
  - [15] running.
  - [1] count done.
  - [0] timer done.
  - All other bits read as 0.
- Mode write:
  - Stores the mode fields and clears running.
  - Sets the channel's CTC_output to 1 and clears the prescaler.
  - Leaves counter and done flags unchanged.
- Init write of value V:
  - Sets init=V, counter=V and clears the prescaler.
  - Sets running=1 if V≠0, else running=0.
- Tick:
  - Timer mode: one tick when the prescaler reaches P; the prescaler then wraps to 0. This gives one tick every P+1 clocks.
  - Counter mode: one tick per synchronised rising edge of Pulse_in[ch].
- On a tick while running:
  - If counter≠1: counter decrements by 1.
  - If counter==1 (terminal): set done bit (bit0 in timer mode, bit1 in counter mode).
  - At terminal with auto-reload: counter=init.
  - At terminal without auto-reload: counter=0 and running=0.
- Output at terminal:
  - Pulse style: CTC_output low for exactly one clock.
  - Toggle style: CTC_output inverts.
  - Otherwise it holds its value; it is 1 whenever the channel is not running and in pulse style.
- Status read is read-to-clear:
  - Returns the current status and clears only bits [1:0] that were 1 in the returned value.
  - A done bit set in the same cycle survives for the next read.
- irq = OR over channels of (mode[2] & (status[1] | status[0])).
- Reads of reserved bits return 0. Read_data_out returns 0 on any cycle with no valid read.

## Timing
- Reset values:
  - Read_data_out=0, CTC_output=all 1s, irq=0.
  - All mode, status, init, counter and prescaler registers are 0.
  - Synchroniser flops are 0.
- Reset mid-operation clears everything immediately. There are no ticks until the first clock edge after reset is released.
- Read latency is 1: a read sampled at edge t presents data after edge t and holds it until edge t+1.
- Init written at edge t:
  - With P=0 the counter decrements from edge t+1.
  - Terminal is processed at edge t+V; with auto-reload the period is V clocks.
  - With prescale P the period is V·(P+1) clocks.
- Pulse_in path is a 2-flop synchroniser plus an edge register. An edge sampled at clock edge k ticks the counter at edge k+3.
- Pulse_in must hold each level for at least 2 clocks.
- Same-cycle collisions:
  - A bus write to mode or init wins over a tick on that channel; the tick is dropped.
  - A read of status concurrent with a terminal returns the pre-terminal value, and the new done bit remains set.
- Counter arithmetic is WIDTH-bit unsigned and never underflows: terminal is at 1, and 0 means idle.

## Test plan
- Reset, then read all registers of channel 1 → all 0, CTC_output all 1s, irq=0.
- Channel 0: mode=0x0006 (timer, reload, irq), init=5 → CTC_output[0] low for 1 clock every 5 clocks. irq rises on the first terminal. A status read returns 0x8001; a second read returns 0x8000 and irq falls.
- Channel 1: mode=0x0301 (counter, one-shot, P ignored), init=3, then 3 Pulse_in[1] pulses → counter reads 2, 1, 0 three clocks after each edge. Status reads 0x0002 (running cleared); a 4th pulse has no effect.
- Timer with P=3, toggle style (mode=0x030A), init=2 → CTC_output toggles every 8 clocks.
- Write init=7 in the same cycle as a terminal tick → counter=7, done not set, no output pulse. Write init=0 → running=0 and status=0.
- Assert reset mid-count → every output returns to its reset value immediately. After release, counter and status read 0.

Source files
------------

// File: rtl/ctc_multi.sv
// ctc_multi: multi-channel counter/timer controller on the CPU I/O bus.
//
// Each channel is an independent WIDTH-bit down-counter. It is ticked
// either by a prescaled system clock (timer mode) or by synchronised
// rising edges on its external pulse input (counter mode). Terminal
// count sets a sticky done flag, optionally reloads the counter, and
// drives the channel output as a one-clock low pulse or as a toggle.
//
// Ports
//   clock          system clock, rising-edge active
//   reset          asynchronous active-low reset
//   Select         chip select; bus strobes are ignored while low
//   Read_enable    read strobe, wins over Write_enable
//   Write_enable   write strobe
//   Address        {channel, reg[1:0]}; reg 0 mode, 1 status, 2 init, 3 counter
//   Write_data_in  write data
//   Read_data_out  registered read data, 0 on cycles with no read
//   Pulse_in       asynchronous per-channel count pulses
//   CTC_output     per-channel output (idle high)
//   irq            OR of enabled per-channel done flags

package ctc_multi_pkg;

  // Per-channel bus strobes, already decoded from address and select.
  typedef struct packed {
    logic wr_mode;
    logic wr_init;
    logic rd_stat;
  } chan_req_t;

  typedef struct packed {
    logic [7:0] presc;
    logic       tog;
    logic       ien;
    logic       reload;
    logic       ctr;
  } mode_t;

endpackage

// ctc_chan: one counter/timer channel.
//
// Ports
//   clock, reset   shared clock and asynchronous active-low reset
//   req            decoded mode write / init write / status read strobes
//   wdata          bus write data
//   pulse          raw asynchronous count pulse for this channel
//   mode_rd        mode register as read back on the bus
//   stat_rd        status register as read back (pre-clear value)
//   init_rd        reload value
//   cnt_rd         current counter
//   out            channel output
//   irq            this channel's interrupt request
module ctc_chan
  import ctc_multi_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  chan_req_t        req,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pulse,
  output logic [WIDTH-1:0] mode_rd,
  output logic [WIDTH-1:0] stat_rd,
  output logic [WIDTH-1:0] init_rd,
  output logic [WIDTH-1:0] cnt_rd,
  output logic             out,
  output logic             irq
);

  mode_t            mode;
  logic             running;
  logic             tdone;
  logic             cdone;
  logic [WIDTH-1:0] init;
  logic [WIDTH-1:0] cnt;
  logic [7:0]       pre;

  // Two synchroniser flops plus one history flop; edge_q registers the
  // detected rise so an edge sampled at clock k ticks at clock k+3.
  logic [2:0]       sync_pipe;
  logic             edge_q;

  logic             wr;
  logic             tick;
  logic             step;
  logic             term;
  logic             pre_hit;

  // Mode bits [7:4] are reserved and never stored.
  logic             unused_wdata;
  assign unused_wdata = ^wdata[7:4];

  assign wr      = req.wr_mode | req.wr_init;
  assign pre_hit = (pre == mode.presc);
  assign tick    = mode.ctr ? edge_q : pre_hit;
  // A bus write to mode or init on this channel swallows a coincident tick.
  assign step    = running & tick & ~wr;
  assign term    = step & (cnt == WIDTH'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_pipe <= '0;
      edge_q    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], pulse};
      edge_q    <= sync_pipe[1] & ~sync_pipe[2];
    end
  end

  // Prescaler only advances while a timer is running; P+1 clocks per tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (wr || !running || mode.ctr) begin
      pre <= '0;
    end else if (pre_hit) begin
      pre <= '0;
    end else begin
      pre <= pre + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode    <= '0;
      running <= 1'b0;
      init    <= '0;
      cnt     <= '0;
    end else if (req.wr_mode) begin
      mode.ctr    <= wdata[0];
      mode.reload <= wdata[1];
      mode.ien    <= wdata[2];
      mode.tog    <= wdata[3];
      mode.presc  <= wdata[15:8];
      running     <= 1'b0;
    end else if (req.wr_init) begin
      init    <= wdata;
      cnt     <= wdata;
      running <= |wdata;
    end else if (step) begin
      if (!term) begin
        cnt <= cnt - WIDTH'(1);
      end else if (mode.reload) begin
        cnt <= init;
      end else begin
        cnt     <= '0;
        running <= 1'b0;
      end
    end
  end

  // Read-to-clear: only flags present in the value returned are cleared,
  // so a flag raised by a terminal in the same cycle survives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tdone <= 1'b0;
      cdone <= 1'b0;
    end else begin
      tdone <= (tdone & ~req.rd_stat) | (term & ~mode.ctr);
      cdone <= (cdone & ~req.rd_stat) | (term & mode.ctr);
    end
  end

  // Pulse style sits at 1 except for the terminal clock; toggle style
  // holds its level between terminals.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out <= 1'b1;
    end else if (req.wr_mode) begin
      out <= 1'b1;
    end else if (term) begin
      out <= mode.tog ? ~out : 1'b0;
    end else if (!mode.tog) begin
      out <= 1'b1;
    end
  end

  always_comb begin
    mode_rd       = '0;
    mode_rd[0]    = mode.ctr;
    mode_rd[1]    = mode.reload;
    mode_rd[2]    = mode.ien;
    mode_rd[3]    = mode.tog;
    mode_rd[15:8] = mode.presc;
    stat_rd       = '0;
    stat_rd[15]   = running;
    stat_rd[1]    = cdone;
    stat_rd[0]    = tdone;
  end

  assign init_rd = init;
  assign cnt_rd  = cnt;
  assign irq     = mode.ien & (cdone | tdone);

endmodule

module ctc_multi
  import ctc_multi_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int AW       = $clog2(CHANNELS) + 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Select,
  input  logic                Read_enable,
  input  logic                Write_enable,
  input  logic [AW-1:0]       Address,
  input  logic [WIDTH-1:0]    Write_data_in,
  output logic [WIDTH-1:0]    Read_data_out,
  input  logic [CHANNELS-1:0] Pulse_in,
  output logic [CHANNELS-1:0] CTC_output,
  output logic                irq
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CW-1:0]                  ch_sel;
  logic [1:0]                     reg_sel;
  logic                           rd;
  logic                           wr;
  logic [CHANNELS-1:0][WIDTH-1:0] mode_rd;
  logic [CHANNELS-1:0][WIDTH-1:0] stat_rd;
  logic [CHANNELS-1:0][WIDTH-1:0] init_rd;
  logic [CHANNELS-1:0][WIDTH-1:0] cnt_rd;
  logic [CHANNELS-1:0]            irq_ch;
  logic [WIDTH-1:0]               rmux;

  generate
    if (CHANNELS > 1) begin : g_sel
      assign ch_sel = Address[AW-1:2];
    end else begin : g_sel1
      assign ch_sel = '0;
    end
  endgenerate

  assign reg_sel = Address[1:0];
  assign rd      = Select & Read_enable;
  assign wr      = Select & Write_enable & ~Read_enable;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic      hit;
      chan_req_t r;

      assign hit = (ch_sel == CW'(g));
      assign r   = '{wr_mode: wr & hit & (reg_sel == 2'd0),
                     wr_init: wr & hit & (reg_sel == 2'd2),
                     rd_stat: rd & hit & (reg_sel == 2'd1)};

      ctc_chan #(.WIDTH(WIDTH)) u_chan (
        .clock   (clock),
        .reset   (reset),
        .req     (r),
        .wdata   (Write_data_in),
        .pulse   (Pulse_in[g]),
        .mode_rd (mode_rd[g]),
        .stat_rd (stat_rd[g]),
        .init_rd (init_rd[g]),
        .cnt_rd  (cnt_rd[g]),
        .out     (CTC_output[g]),
        .irq     (irq_ch[g])
      );
    end
  endgenerate

  always_comb begin
    rmux = '0;
    case (reg_sel)
      2'd0:    rmux = mode_rd[ch_sel];
      2'd1:    rmux = stat_rd[ch_sel];
      2'd2:    rmux = init_rd[ch_sel];
      default: rmux = cnt_rd[ch_sel];
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Read_data_out <= '0;
    end else begin
      Read_data_out <= rd ? rmux : '0;
    end
  end

  assign irq = |irq_ch;

endmodule

// File: tb/tb_ctc_multi.sv
// Scoreboard bench for ctc_multi (2 channels, 16-bit). Reads push their
// expected data into a queue; a monitor pops and compares on the falling
// edge after the read is sampled. Output and irq levels are checked
// directly by the stimulus at falling edges.
module tb_ctc_multi;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        Select = 1'b0;
  logic        Read_enable = 1'b0;
  logic        Write_enable = 1'b0;
  logic [2:0]  Address = '0;
  logic [15:0] Write_data_in = '0;
  logic [15:0] Read_data_out;
  logic [1:0]  Pulse_in = '0;
  logic [1:0]  CTC_output;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;

  ctc_multi #(.CHANNELS(2), .WIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .Select        (Select),
    .Read_enable   (Read_enable),
    .Write_enable  (Write_enable),
    .Address       (Address),
    .Write_data_in (Write_data_in),
    .Read_data_out (Read_data_out),
    .Pulse_in      (Pulse_in),
    .CTC_output    (CTC_output),
    .irq           (irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rd_seen <= Select & Read_enable;

  // Monitor: read data is valid on the falling edge after the sample edge.
  always @(negedge clock) begin
    if (rd_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: read data %h with no expectation", Read_data_out);
      end else begin
        logic [15:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (Read_data_out !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, Read_data_out, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    Select = 1'b1; Write_enable = 1'b1; Address = a; Write_data_in = d;
    @(negedge clock);
    Select = 1'b0; Write_enable = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    Select = 1'b1; Read_enable = 1'b1; Address = a;
    @(negedge clock);
    Select = 1'b0; Read_enable = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    chk("rst_rdata", Read_data_out, 16'h0000);
    chk("rst_out", {14'b0, CTC_output}, 16'h0003);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    reset = 1'b1;
    rd(3'd4, 16'h0000, "c1_mode_rst");
    rd(3'd5, 16'h0000, "c1_stat_rst");
    rd(3'd6, 16'h0000, "c1_init_rst");
    rd(3'd7, 16'h0000, "c1_cnt_rst");

    // Channel 0: timer, reload, irq, period 5, pulse output
    wr(3'd0, 16'h0006);
    wr(3'd2, 16'd5);
    idle(4);
    chk("t0_out_pre", {15'b0, CTC_output[0]}, 16'h0001);
    chk("t0_irq_pre", {15'b0, irq}, 16'h0000);
    idle(1);
    chk("t0_out_term", {15'b0, CTC_output[0]}, 16'h0000);
    chk("t0_irq_term", {15'b0, irq}, 16'h0001);
    idle(1);
    chk("t0_out_post", {15'b0, CTC_output[0]}, 16'h0001);
    rd(3'd1, 16'h8001, "t0_stat1");
    chk("t0_irq_clr", {15'b0, irq}, 16'h0000);
    rd(3'd1, 16'h8000, "t0_stat2");
    idle(2);
    chk("t0_out_term2", {15'b0, CTC_output[0]}, 16'h0000);
    rd(3'd3, 16'd5, "t0_cnt_reload");
    rd(3'd0, 16'h0006, "t0_mode_rb");
    wr(3'd0, 16'h0000);

    // Channel 1: counter mode, one-shot, init 3
    wr(3'd4, 16'h0301);
    wr(3'd6, 16'd3);
    rd(3'd4, 16'h0301, "c1_mode_rb");
    for (int i = 0; i < 3; i++) begin
      Pulse_in[1] = 1'b1;
      idle(2);
      Pulse_in[1] = 1'b0;
      idle(1);
      rd(3'd7, 16'(3 - i), "c1_cnt_before");
      chk("c1_out", {15'b0, CTC_output[1]}, (i == 2) ? 16'h0000 : 16'h0001);
      rd(3'd7, 16'(2 - i), "c1_cnt_after");
    end
    rd(3'd5, 16'h0002, "c1_stat_done");
    Pulse_in[1] = 1'b1;
    idle(2);
    Pulse_in[1] = 1'b0;
    idle(3);
    rd(3'd7, 16'h0000, "c1_cnt_idle");
    rd(3'd5, 16'h0000, "c1_stat_clr");
    chk("c1_irq", {15'b0, irq}, 16'h0000);

    // Channel 1: timer P=3, toggle, reload, init 2 -> toggle every 8 clocks
    wr(3'd4, 16'h030A);
    chk("tg_out_mode", {15'b0, CTC_output[1]}, 16'h0001);
    wr(3'd6, 16'd2);
    idle(7);
    chk("tg_out_7", {15'b0, CTC_output[1]}, 16'h0001);
    idle(1);
    chk("tg_out_8", {15'b0, CTC_output[1]}, 16'h0000);
    idle(7);
    chk("tg_out_15", {15'b0, CTC_output[1]}, 16'h0000);
    idle(1);
    chk("tg_out_16", {15'b0, CTC_output[1]}, 16'h0001);

    // Init write colliding with the terminal tick at +24
    rd(3'd5, 16'h8001, "tg_stat");
    idle(6);
    wr(3'd6, 16'd7);
    chk("col_out", {15'b0, CTC_output[1]}, 16'h0001);
    rd(3'd5, 16'h8000, "col_stat");
    rd(3'd7, 16'd7, "col_cnt");
    wr(3'd6, 16'd0);
    rd(3'd5, 16'h0000, "init0_stat");
    rd(3'd7, 16'h0000, "init0_cnt");

    // Status read concurrent with terminal, then reset mid-count
    rd(3'd1, 16'h0001, "c0_stale_done");
    wr(3'd0, 16'h0006);
    wr(3'd2, 16'd5);
    idle(4);
    rd(3'd1, 16'h8000, "c0_stat_at_term");
    chk("c0_out_term", {15'b0, CTC_output[0]}, 16'h0000);
    chk("c0_irq_kept", {15'b0, irq}, 16'h0001);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rdata", Read_data_out, 16'h0000);
    chk("mid_rst_out", {14'b0, CTC_output}, 16'h0003);
    chk("mid_rst_irq", {15'b0, irq}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    rd(3'd3, 16'h0000, "post_rst_cnt");
    rd(3'd1, 16'h0000, "post_rst_stat");
    rd(3'd0, 16'h0000, "post_rst_mode");
    chk("post_rst_out", {14'b0, CTC_output}, 16'h0003);

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
